// File: rtl/rbb_drain.sv
// Drains the result buffer into WPL-word cache lines: WPL reads, one flush cycle, then a held write until wr_ready.
// Stalls only in WRITE (wr_valid held stable). Optional byte reversal of each word when RBB_DRAIN_BYTESWAP_EN is defined.
module rbb_drain #(
  parameter int RBB_DATA_WIDTH = 32,
  parameter int RBB_ADDR_WIDTH = 12,
  parameter int LINE_WIDTH     = 512,
  localparam int WPL           = LINE_WIDTH / RBB_DATA_WIDTH,
  localparam int KW            = $clog2(WPL),
  localparam int LW            = RBB_ADDR_WIDTH - KW
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pe2bm_done,
  output logic [RBB_ADDR_WIDTH-1:0] bm2pe_rbbRdAddr,
  input  logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbRdDout,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [LW-1:0]             wr_line,
  output logic [LINE_WIDTH-1:0]     wr_data,
  output logic                      drain_busy,
  output logic                      drain_done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_WRITE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           line_q, line_d;
  logic [KW-1:0]           k_q, k_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d;
  logic [RBB_DATA_WIDTH-1:0] cap_word;
  logic [KW-1:0]           cap_lane;
  logic                    cap_en;

`ifdef RBB_DRAIN_BYTESWAP_EN
  function automatic logic [RBB_DATA_WIDTH-1:0] bswap(input logic [RBB_DATA_WIDTH-1:0] w);
    logic [RBB_DATA_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < RBB_DATA_WIDTH / 8; b++) begin
      r[b*8 +: 8] = w[RBB_DATA_WIDTH-8-b*8 +: 8];
    end
    return r;
  endfunction
  assign cap_word = bswap(pe2bm_rbbRdDout);
`else
  assign cap_word = pe2bm_rbbRdDout;
`endif

  // Read data lags its address by one cycle; in FLUSH k_q has wrapped to 0, so k_q-1 selects the last lane.
  assign cap_en   = (state_q == S_READ && k_q != '0) || (state_q == S_FLUSH);
  assign cap_lane = k_q - 1'b1;

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    k_d     = k_q;
    data_d  = data_q;
    for (int i = 0; i < WPL; i++) begin
      if (cap_en && cap_lane == KW'(i)) begin
        data_d[i*RBB_DATA_WIDTH +: RBB_DATA_WIDTH] = cap_word;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (pe2bm_done) begin
          state_d = S_READ;
          line_d  = '0;
          k_d     = '0;
        end
      end
      S_READ: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(WPL - 1)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_WRITE;
      S_WRITE: begin
        if (wr_ready) begin
          k_d = '0;
          if (line_q == '1) begin
            state_d = S_DONE;
            line_d  = '0;
          end else begin
            state_d = S_READ;
            line_d  = line_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      k_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

  assign bm2pe_rbbRdAddr = (state_q == S_READ) ? {line_q, k_q} : '0;
  assign wr_valid        = (state_q == S_WRITE);
  assign wr_line         = line_q;
  assign wr_data         = data_q;
  assign drain_busy      = (state_q == S_READ) || (state_q == S_FLUSH) || (state_q == S_WRITE);
  assign drain_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_rbb_drain.sv
// Randomized bench for rbb_drain with a cycle-level behavioural model and a few literal pins.
module tb_rbb_drain;

  logic         clk = 1'b0;
  logic         reset;
  logic         pe2bm_done;
  logic [11:0]  bm2pe_rbbRdAddr;
  logic [31:0]  pe2bm_rbbRdDout;
  logic         wr_valid;
  logic         wr_ready;
  logic [7:0]   wr_line;
  logic [511:0] wr_data;
  logic         drain_busy;
  logic         drain_done;

  rbb_drain dut (
    .clk(clk), .reset(reset), .pe2bm_done(pe2bm_done),
    .bm2pe_rbbRdAddr(bm2pe_rbbRdAddr), .pe2bm_rbbRdDout(pe2bm_rbbRdDout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_line(wr_line), .wr_data(wr_data),
    .drain_busy(drain_busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  logic [31:0]  mem [4096];
  logic [511:0] got_line [256];

  // Result buffer: one-cycle read latency.
  always @(posedge clk) pe2bm_rbbRdDout <= mem[bm2pe_rbbRdAddr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] swp(input logic [31:0] w);
`ifdef RBB_DRAIN_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [511:0] exp_line(input int l);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = swp(mem[l*16 + k]);
    return r;
  endfunction

  // Model: a drain is a run of lines, each 16 read cycles, 1 flush cycle, then write cycles until accepted.
  bit chk_en = 0;
  bit mbusy = 0, mdone = 0;
  int mline = 0, mcyc = 0;
  int ncyc = 0, start_n = 0, last_lat = 0;
  int n_hs = 0, n_done = 0;

  always @(negedge clk) begin
    int exp_addr;
    ncyc++;
    if (chk_en) begin
      exp_addr = (mbusy && mcyc < 16) ? mline * 16 + mcyc : 0;
      chk("rd_addr", bm2pe_rbbRdAddr, exp_addr);
      chk("wr_valid", wr_valid, mbusy && mcyc >= 17);
      chk("drain_busy", drain_busy, mbusy);
      chk("drain_done", drain_done, mdone);
      chk("wr_line", wr_line, mline);
      if (mbusy && mcyc >= 17) chk("wr_data", wr_data, exp_line(mline));
      if (wr_valid && wr_ready) begin
        n_hs++;
        got_line[wr_line] = wr_data;
      end
      if (drain_done) begin
        n_done++;
        last_lat = ncyc - start_n;
      end
      if (reset) begin
        mbusy = 0; mdone = 0; mline = 0; mcyc = 0;
      end else if (mdone) begin
        mdone = 0;
      end else if (!mbusy) begin
        if (pe2bm_done) begin
          mbusy = 1; mline = 0; mcyc = 0; start_n = ncyc;
        end
      end else if (mcyc < 17) begin
        mcyc++;
      end else if (wr_ready) begin
        if (mline == 255) begin
          mbusy = 0; mdone = 1; mline = 0;
        end else begin
          mline++; mcyc = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    pe2bm_done = 1'b1;
    step();
    pe2bm_done = 1'b0;
  endtask

  // sel 0: drain_done, 1: rd addr == arg, 2: wr_valid
  task automatic wait_until(input int sel, input int arg, input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if ((sel == 0 && drain_done) || (sel == 1 && bm2pe_rbbRdAddr == 12'(arg)) ||
          (sel == 2 && wr_valid)) return;
      step();
    end
    chk({"timeout ", nm}, 1'b0, 1'b1);
  endtask

  initial begin
    int hs0, dn0;
    logic [511:0] snap;
    reset = 1'b1; pe2bm_done = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = i;
    repeat (3) step();
    chk_en = 1;
    step();
    chk("rst wr_valid", wr_valid, 1'b0);
    chk("rst busy", drain_busy, 1'b0);
    chk("rst done", drain_done, 1'b0);
    chk("rst addr", bm2pe_rbbRdAddr, 0);
    chk("rst wr_line", wr_line, 0);
    chk("rst wr_data", wr_data, 0);
    reset = 1'b0;
    step();

    // Identity buffer, always ready.
    hs0 = n_hs;
    pulse();
    wait_until(0, 0, 6000, "drain1");
    step();
    chk("t1 latency", last_lat, 4609);
    chk("t1 handshakes", n_hs - hs0, 256);
    chk("t1 line0 lane1", got_line[0][1*32 +: 32], swp(32'd1));
    chk("t1 line0 lane15", got_line[0][15*32 +: 32], swp(32'd15));
    chk("t1 line255 lane15", got_line[255][15*32 +: 32], swp(32'h0000_0FFF));

    // Random data, 10-cycle stall on line 3, pe2bm_done in the DONE cycle.
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h1234_5678;
    pulse();
    wait_until(1, 48, 200, "line3 read");
    wr_ready = 1'b0;
    wait_until(2, 0, 40, "line3 write");
    snap = wr_data;
    for (int i = 0; i < 10; i++) begin
      chk("stall wr_valid", wr_valid, 1'b1);
      chk("stall wr_line", wr_line, 8'd3);
      chk("stall wr_data", wr_data, snap);
      chk("stall rd_addr", bm2pe_rbbRdAddr, 0);
      step();
    end
    wr_ready = 1'b1;
    step();
    chk("post-accept wr_valid", wr_valid, 1'b0);
    chk("post-accept wr_line", wr_line, 8'd4);
    wait_until(0, 0, 6000, "drain2");
    pe2bm_done = 1'b1;
    step();
    pe2bm_done = 1'b0;
    step();
    chk("done-cycle start ignored", drain_busy, 1'b0);
    chk("lane0 word0", got_line[0][31:0], swp(32'h1234_5678));

    // Random backpressure and repeated pe2bm_done during the drain.
    hs0 = n_hs; dn0 = n_done;
    pulse();
    for (int i = 0; i < 20000 && !drain_done; i++) begin
      wr_ready   = 1'($urandom_range(0, 1));
      pe2bm_done = ($urandom_range(0, 7) == 0);
      step();
    end
    chk("t3 drain_done seen", drain_done, 1'b1);
    pe2bm_done = 1'b0;
    wr_ready = 1'b1;
    step();
    chk("t3 handshakes", n_hs - hs0, 256);
    chk("t3 done pulses", n_done - dn0, 1);
    pulse();
    chk("start after done", drain_busy, 1'b1);

    // Reset during line 100 WRITE, then restart from line 0.
    wait_until(1, 1600, 3000, "line100 read");
    wr_ready = 1'b0;
    wait_until(2, 0, 40, "line100 write");
    chk("line100 wr_line", wr_line, 8'd100);
    reset = 1'b1;
    dn0 = n_done;
    step();
    chk("mid rst wr_valid", wr_valid, 1'b0);
    chk("mid rst busy", drain_busy, 1'b0);
    chk("mid rst wr_line", wr_line, 0);
    reset = 1'b0;
    wr_ready = 1'b1;
    repeat (3) step();
    chk("mid rst no done", n_done - dn0, 0);
    hs0 = n_hs;
    pulse();
    wait_until(0, 0, 6000, "drain4");
    step();
    chk("t4 handshakes", n_hs - hs0, 256);
    chk("t4 latency", last_lat, 4609);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
